// File: rtl/fft64_pkg.sv
// Shared constants, state encoding and index helper for the 64-point DIF twiddle stage.
package fft64_pkg;

  localparam int unsigned FFT_N = 64;
  localparam int unsigned IDX_W = 6;

  // Index ordering selectors for the ORDER parameter
  localparam int unsigned ORDER_LINEAR = 0;
  localparam int unsigned ORDER_SWAP   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tm_state_e;

  // Swap the two 3-bit fields of a 6-bit sample count
  function automatic logic [IDX_W-1:0] swap_fields(input logic [IDX_W-1:0] c);
    return {c[2:0], c[5:3]};
  endfunction

endpackage

// File: rtl/dif_radix2_64p_tm_ctrl_if.sv
// Stream handshake and multiplier control bundle for the twiddle stage controller.
interface dif_radix2_64p_tm_ctrl_if;
  import fft64_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic             m_first;
  logic             m_last;
  logic [IDX_W-1:0] tm64_ctrl;
  logic             halt_ctrl;

  // Controller side
  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, m_first, m_last, tm64_ctrl, halt_ctrl
  );

  // Environment side (upstream, downstream and multiplier)
  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, m_first, m_last, tm64_ctrl, halt_ctrl
  );

endinterface

// File: rtl/dif_radix2_64p_tm_ctrl.sv
// Sequencer for the 64-point radix-2 DIF twiddle multiplier stage: counts samples,
// generates the twiddle index, drives the multiplier load enable and tracks frames.
module dif_radix2_64p_tm_ctrl
  import fft64_pkg::*;
#(
  parameter int unsigned ORDER       = 0,
  parameter bit          CONTINUOUS  = 1'b0,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       bypass,
  dif_radix2_64p_tm_ctrl_if.master   strm,
  output logic                       busy,
  output logic                       frame_done,
  output logic [FRAME_CNT_W-1:0]     frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

  tm_state_e               state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_first_q, m_first_d;
  logic                    m_last_q, m_last_d;
  logic                    frame_done_q, frame_done_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                    bypass_q, bypass_d;

  logic en_c;
  logic s_ready_c;
  logic accept_c;

  // Single-stage pipeline advances when the output slot is empty or being drained
  assign en_c      = ~m_valid_q | strm.m_ready;
  assign s_ready_c = (state_q == ST_RUN) & en_c;
  assign accept_c  = strm.s_valid & s_ready_c;

  // Next-state, counter and output flag logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    m_valid_d    = m_valid_q;
    m_first_d    = m_first_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    bypass_d     = bypass_q;

    if (abort) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      m_valid_d = 1'b0;
      m_first_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      if (en_c) begin
        m_valid_d = accept_c;
        m_first_d = accept_c & (cnt_q == '0);
        m_last_d  = accept_c & (cnt_q == LAST_IDX);
      end

      case (state_q)
        ST_IDLE: begin
          if (start || CONTINUOUS) begin
            state_d  = ST_RUN;
            bypass_d = bypass;
            cnt_d    = '0;
          end
        end
        ST_RUN: begin
          if (accept_c) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (m_valid_q && strm.m_ready && m_last_q) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
            if (CONTINUOUS) begin
              state_d  = ST_RUN;
              bypass_d = bypass;
              cnt_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      m_valid_q    <= 1'b0;
      m_first_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      bypass_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      m_valid_q    <= m_valid_d;
      m_first_q    <= m_first_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      bypass_q     <= bypass_d;
    end
  end

  // Index is combinational from the count so the multiplier decodes it alongside din
  assign strm.tm64_ctrl = bypass_q ? '0
                        : ((ORDER == ORDER_SWAP) ? swap_fields(cnt_q) : cnt_q);

  assign strm.s_ready   = s_ready_c;
  assign strm.halt_ctrl = en_c;
  assign strm.m_valid   = m_valid_q;
  assign strm.m_first   = m_first_q;
  assign strm.m_last    = m_last_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = frame_done_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_dif_radix2_64p_tm_ctrl.sv
// Directed bench for the twiddle stage controller with a stand-in multiplier register.
module tb_dif_radix2_64p_tm_ctrl;

  logic clk;
  logic rst_n;
  logic start, abort, bypass;
  logic s_valid, m_ready;
  logic [7:0] din, dout;

  logic       busy0, busy1, busy2;
  logic       fd0, fd1, fd2;
  logic [7:0] fc0, fc1;
  logic [1:0] fc2;

  int n_cmp = 0;
  int n_err = 0;

  dif_radix2_64p_tm_ctrl_if if0 ();
  dif_radix2_64p_tm_ctrl_if if1 ();
  dif_radix2_64p_tm_ctrl_if if2 ();

  assign if0.s_valid = s_valid;
  assign if0.m_ready = m_ready;
  assign if1.s_valid = s_valid;
  assign if1.m_ready = m_ready;

  dif_radix2_64p_tm_ctrl #(.ORDER(0), .CONTINUOUS(1'b0), .FRAME_CNT_W(8)) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bypass(bypass),
    .strm(if0), .busy(busy0), .frame_done(fd0), .frame_cnt(fc0)
  );

  dif_radix2_64p_tm_ctrl #(.ORDER(1), .CONTINUOUS(1'b0), .FRAME_CNT_W(8)) u_swp (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bypass(bypass),
    .strm(if1), .busy(busy1), .frame_done(fd1), .frame_cnt(fc1)
  );

  dif_radix2_64p_tm_ctrl #(.ORDER(0), .CONTINUOUS(1'b1), .FRAME_CNT_W(2)) u_cont (
    .clk(clk), .rst_n(rst_n), .start(1'b0), .abort(1'b0), .bypass(1'b0),
    .strm(if2), .busy(busy2), .frame_done(fd2), .frame_cnt(fc2)
  );

  // Stand-in multiplier output register, loaded under halt_ctrl
  always_ff @(posedge clk) begin
    if (if0.halt_ctrl) dout <= din;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic byp);
    bypass = byp;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Runs one frame with all-valid input, optional output stall at a given sample
  task automatic run_frame(input int stall_at, input int stall_len, input logic byp);
    int in_idx  = 0;
    int out_idx = 0;
    int stalls  = 0;
    bit done    = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (in_idx == stall_at && stalls < stall_len && if0.m_valid) m_ready = 1'b0;
      else m_ready = 1'b1;
      din = 8'(in_idx);
      #1;
      if (!m_ready) begin
        stalls++;
        chk("stall_s_ready", 32'(if0.s_ready), 32'(0));
        chk("stall_halt", 32'(if0.halt_ctrl), 32'(0));
        chk("stall_tm", 32'(if0.tm64_ctrl), 32'(stall_at));
        chk("stall_dout", 32'(dout), 32'(stall_at - 1));
      end
      if (if0.s_ready && s_valid) begin
        chk(byp ? "byp_tm" : "run_tm", 32'(if0.tm64_ctrl), byp ? 32'(0) : 32'(in_idx));
        in_idx++;
      end
      if (if0.m_valid && m_ready) begin
        chk("out_data", 32'(dout), 32'(out_idx));
        chk("out_first", 32'(if0.m_first), 32'(out_idx == 0));
        chk("out_last", 32'(if0.m_last), 32'(out_idx == 63));
        out_idx++;
      end
      if (fd0) done = 1'b1;
      step();
    end
    m_ready = 1'b1;
    chk("frame_in_count", 32'(in_idx), 32'(64));
    chk("frame_out_count", 32'(out_idx), 32'(64));
    chk("frame_done_seen", 32'(done), 32'(1));
    chk("frame_stalls", 32'(stalls), 32'(stall_len));
  endtask

  initial begin
    int frames;
    int nout;
    int idle_cyc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bypass = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0; din = 8'd0;
    if2.s_valid = 1'b0; if2.m_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_busy", 32'(busy0), 32'(0));
    chk("rst_s_ready", 32'(if0.s_ready), 32'(0));
    chk("rst_halt", 32'(if0.halt_ctrl), 32'(1));
    chk("rst_tm", 32'(if0.tm64_ctrl), 32'(0));
    chk("rst_m_valid", 32'(if0.m_valid), 32'(0));
    chk("rst_m_first", 32'(if0.m_first), 32'(0));
    chk("rst_m_last", 32'(if0.m_last), 32'(0));
    chk("rst_frame_done", 32'(fd0), 32'(0));
    chk("rst_frame_cnt", 32'(fc0), 32'(0));
    rst_n = 1'b1;
    step();
    step();
    chk("idle_s_ready", 32'(if0.s_ready), 32'(0));

    // Full-rate frame, linear and swapped ordering
    s_valid = 1'b1;
    m_ready = 1'b1;
    do_start(1'b0);
    for (int k = 0; k < 64; k++) begin
      din = 8'(k);
      #1;
      chk("t1_tm", 32'(if0.tm64_ctrl), 32'(k));
      chk("t1_s_ready", 32'(if0.s_ready), 32'(1));
      chk("t1_m_valid", 32'(if0.m_valid), 32'(k != 0));
      chk("t1_m_first", 32'(if0.m_first), 32'(k == 1));
      if (k >= 1) chk("t1_dout", 32'(dout), 32'(k - 1));
      if (k == 9)  chk("swap_9", 32'(if1.tm64_ctrl), 32'(6'b001001));
      if (k == 12) chk("swap_12", 32'(if1.tm64_ctrl), 32'(6'b100001));
      if (k == 1)  chk("swap_1", 32'(if1.tm64_ctrl), 32'(6'b001000));
      step();
    end
    chk("t1_drain_m_last", 32'(if0.m_last), 32'(1));
    chk("t1_drain_m_valid", 32'(if0.m_valid), 32'(1));
    chk("t1_drain_s_ready", 32'(if0.s_ready), 32'(0));
    chk("t1_drain_dout", 32'(dout), 32'(63));
    chk("t1_drain_busy", 32'(busy0), 32'(1));
    chk("t1_drain_fd", 32'(fd0), 32'(0));
    step();
    chk("t1_frame_done", 32'(fd0), 32'(1));
    chk("t1_frame_cnt", 32'(fc0), 32'(1));
    chk("t1_idle_busy", 32'(busy0), 32'(0));
    chk("t1_idle_m_valid", 32'(if0.m_valid), 32'(0));
    step();
    chk("t1_fd_pulse", 32'(fd0), 32'(0));

    // Back-pressure: output stalled 5 cycles while sample 20 is offered
    do_start(1'b0);
    run_frame(20, 5, 1'b0);
    chk("t2_frame_cnt", 32'(fc0), 32'(2));

    // Bypass latched at start, released right after
    do_start(1'b1);
    bypass = 1'b0;
    run_frame(-1, 0, 1'b1);
    chk("t3_frame_cnt", 32'(fc0), 32'(3));

    // Abort mid-frame
    do_start(1'b0);
    for (int k = 0; k < 30; k++) begin
      din = 8'(k);
      step();
    end
    #1;
    chk("t4_pre_tm", 32'(if0.tm64_ctrl), 32'(30));
    chk("t4_pre_m_valid", 32'(if0.m_valid), 32'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    chk("t4_busy", 32'(busy0), 32'(0));
    chk("t4_m_valid", 32'(if0.m_valid), 32'(0));
    chk("t4_fd", 32'(fd0), 32'(0));
    chk("t4_frame_cnt", 32'(fc0), 32'(3));
    chk("t4_s_ready", 32'(if0.s_ready), 32'(0));
    step();
    chk("t4_fd_after", 32'(fd0), 32'(0));
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    #1;
    chk("t4_abort_beats_start", 32'(busy0), 32'(0));
    do_start(1'b0);
    #1;
    chk("t4_restart_tm", 32'(if0.tm64_ctrl), 32'(0));
    chk("t4_restart_s_ready", 32'(if0.s_ready), 32'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Continuous mode with random handshakes, four frames (wraps 2-bit counter)
    frames = 0;
    nout = 0;
    idle_cyc = 0;
    for (int cyc = 0; cyc < 6000 && frames < 4; cyc++) begin
      if2.s_valid = 1'($urandom_range(0, 1));
      if2.m_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!busy2) idle_cyc++;
      if (if2.m_valid && if2.m_ready) nout++;
      if (fd2) begin
        frames++;
        if (frames == 3) chk("t5_frame_cnt_3", 32'(fc2), 32'(3));
        if (frames == 4) chk("t5_frame_cnt_wrap", 32'(fc2), 32'(0));
      end
      step();
    end
    if2.s_valid = 1'b0;
    chk("t5_frames", 32'(frames), 32'(4));
    chk("t5_outputs", 32'(nout), 32'(256));
    chk("t5_no_gap", 32'(idle_cyc), 32'(0));

    // Asynchronous reset mid-frame
    do_start(1'b0);
    for (int k = 0; k < 10; k++) step();
    #2;
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy0), 32'(0));
    chk("t6_m_valid", 32'(if0.m_valid), 32'(0));
    chk("t6_tm", 32'(if0.tm64_ctrl), 32'(0));
    chk("t6_s_ready", 32'(if0.s_ready), 32'(0));
    chk("t6_halt", 32'(if0.halt_ctrl), 32'(1));
    chk("t6_frame_cnt", 32'(fc0), 32'(0));
    chk("t6_cont_frame_cnt", 32'(fc2), 32'(0));
    chk("t6_cont_busy", 32'(busy2), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dif_radix2_64p_tm_ctrl.md
Name: dif_radix2_64p_tm_ctrl

Overview:
Sequences the 64-point radix-2 DIF twiddle multiplier stage. It runs a valid/ready stream through the multiplier's single registered stage and generates the 6-bit `tm64_ctrl` index for every accepted sample. It drives the multiplier's `halt_ctrl` load-enable and tracks 64-sample frame boundaries. It sits between the preceding butterfly stage and the next butterfly stage; the multiplier itself is instantiated beside it, not inside it.

Parameters:
- ORDER, 0, index ordering: 0 = tm64_ctrl is the sample count; 1 = the two 3-bit fields of the count are swapped ({cnt[2:0], cnt[5:3]}).
- CONTINUOUS, 0, 1 = start the next frame automatically after frame_done, with no start pulse.
- FRAME_CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms a frame (ignored unless IDLE)
- abort  in  1  synchronous frame abort
- bypass  in  1  latched at frame start; forces tm64_ctrl=0 (NOTOUCH) for the whole frame
- s_valid  in  1  upstream sample valid (din aligned)
- s_ready  out  1  upstream ready
- m_valid  out  1  multiplier output valid
- m_ready  in  1  downstream ready
- m_first  out  1  with m_valid: sample 0 of frame
- m_last  out  1  with m_valid: sample 63 of frame
- tm64_ctrl  out  6  to multiplier; combinational from count, aligned with din
- halt_ctrl  out  1  to multiplier; register load enable
- busy  out  1  state != IDLE
- frame_done  out  1  single-cycle pulse
- frame_cnt  out  FRAME_CNT_W  completed frames, wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, m_valid=0, m_first=0, m_last=0, frame_done=0, frame_cnt=0, bypass_q=0.
  - Derived outputs during reset: tm64_ctrl=0, s_ready=0, busy=0, halt_ctrl=1.
- Pipeline enable: en = ~m_valid | m_ready; halt_ctrl = en.
- States:
  - IDLE: s_ready=0. start=1 (or CONTINUOUS=1) -> RUN; latch bypass_q; cnt=0.
  - RUN: s_ready=en. Accept = s_valid & s_ready; cnt increments on accept. Accept with cnt==63 -> DRAIN, cnt wraps to 0.
  - DRAIN: s_ready=0. When m_valid & m_ready & m_last: frame_done=1 next cycle, frame_cnt+1, -> IDLE (or RUN if CONTINUOUS, latching bypass again).
- Index mapping: tm64_ctrl = bypass_q ? 0 : (ORDER ? {cnt[2:0],cnt[5:3]} : cnt). It is valid in the same cycle as the input sample, so the multiplier's combinational decode is sampled at the same edge as din.
- Output flags (latency 1 cycle from accept to m_valid): when en=1,
  - m_valid <= accept;
  - m_first <= accept & cnt==0;
  - m_last <= accept & cnt==63.
  - When en=0 all three hold, and the multiplier holds dout.
- Back-pressure: m_ready=0 with m_valid=1 gives en=0, so s_ready=0 and no count change. No sample is dropped or duplicated.
- Simultaneous events:
  - start while not IDLE: ignored.
  - abort has priority over everything. Next cycle: state=IDLE, cnt=0, m_valid=0, no frame_done, frame_cnt unchanged.
  - abort and start in the same cycle: abort wins; start is dropped.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- frame_cnt wraps 2^FRAME_CNT_W-1 -> 0.

Decomposition:
- Shared package fft64_pkg:
  - FFT_N=64 and IDX_W=6 constants;
  - controller state enum (IDLE/RUN/DRAIN);
  - ORDER encoding constants;
  - a bit-field swap function for the index mapping.
- No sub-module is needed; a single FSM+counter block. Testbench pairs it with the twiddle multiplier and a reference model.

Test Plan:
- start, s_valid=1 and m_ready=1 continuously, ORDER=0 -> tm64_ctrl goes 0..63 on 64 consecutive cycles. m_valid rises one cycle after the first accept. m_first on output 0, m_last on output 63. frame_done one cycle after m_last handshake; frame_cnt=1.
- ORDER=1, sample count 9 -> tm64_ctrl=6'b001001; count 12 -> 6'b100001; count 1 -> 6'b001000.
- m_ready=0 for 5 cycles at sample 20 -> s_ready=0 and halt_ctrl=0 for 5 cycles, tm64_ctrl holds 20, output data unchanged; all 64 outputs delivered exactly once.
- bypass=1 at start, then bypass=0 mid-frame -> tm64_ctrl=0 for all 64 samples.
- abort at sample 30 with m_valid=1 -> next cycle state IDLE, m_valid=0, no frame_done, frame_cnt unchanged. A following start yields tm64_ctrl=0 at first accept.
- CONTINUOUS=1, 3 back-to-back frames with random s_valid/m_ready -> frame_cnt=3, no gap beyond DRAIN. rst_n pulled low mid-frame -> all outputs at reset values asynchronously.
